iterative_mul_fu: RTL and testbench

ITERATIVE_MUL_FU -- requirements
Module: iterative_mul_fu

---
 rtl/iterative_mul_fu.sv | 191 +++++++++++++++++++
 tb/tb_iterative_mul_fu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_mul_fu.sv
// Iterative RISC-V M-extension multiply functional unit.
// Accepts one MUL/MULH/MULHSU/MULHU per issue, computes the magnitude product
// with a 32-step radix-2 shift-add loop, fixes up the sign, and then holds the
// selected 32-bit half on the CDB request until the arbiter grants it.

package procyon_types;
  localparam int TAG_WIDTH = 6;
  typedef logic [31:0]          procyon_data_t;
  typedef logic [TAG_WIDTH-1:0] procyon_tag_t;
  typedef logic [6:0]           procyon_opcode_t;
  typedef logic [31:0]          procyon_addr_t;
endpackage

module iterative_mul_fu
  import procyon_types::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            i_flush,
  input  logic            i_fu_valid,
  input  procyon_opcode_t i_fu_opcode,
  input  procyon_addr_t   i_fu_iaddr,
  input  logic [31:0]     i_fu_insn,
  input  procyon_data_t   i_fu_src_a,
  input  procyon_data_t   i_fu_src_b,
  input  procyon_tag_t    i_fu_tag,
  output logic            o_fu_stall,
  output logic            o_cdb_req,
  input  logic            i_cdb_grant,
  output logic            o_cdb_en,
  output procyon_data_t   o_cdb_data,
  output procyon_tag_t    o_cdb_tag
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Absolute value of an operand when it is interpreted as signed.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    logic [31:0] mag;
    if (is_signed && value[31]) begin
      mag = ~value + 32'd1;
    end else begin
      mag = value;
    end
    return mag;
  endfunction

  mul_state_t    state_r;
  mul_state_t    state_next_s;
  logic [1:0]    op_r;
  procyon_tag_t  tag_r;
  logic          neg_r;
  logic [31:0]   mcand_r;
  logic [63:0]   product_r;
  logic [4:0]    count_r;
  procyon_data_t cdb_data_r;

  logic          accept_s;
  logic          broadcast_s;
  logic          signed_a_s;
  logic          signed_b_s;
  logic          sign_a_s;
  logic          sign_b_s;
  logic [31:0]   mag_a_s;
  logic [31:0]   mag_b_s;
  logic [32:0]   partial_s;
  logic [63:0]   step_s;
  logic [63:0]   final_s;
  procyon_data_t half_s;
  logic          unused_s;

  // Opcode, address and the non-funct3 instruction bits carry no information here.
  assign unused_s = ^{i_fu_opcode, i_fu_iaddr, i_fu_insn[31:14], i_fu_insn[11:0]};

  // Operand signedness from funct3[1:0]; MUL only needs the low half so it runs unsigned.
  always_comb begin
    signed_a_s = 1'b0;
    signed_b_s = 1'b0;
    case (i_fu_insn[13:12])
      2'b01:   begin signed_a_s = 1'b1; signed_b_s = 1'b1; end
      2'b10:   begin signed_a_s = 1'b1; signed_b_s = 1'b0; end
      default: begin signed_a_s = 1'b0; signed_b_s = 1'b0; end
    endcase
    sign_a_s = signed_a_s & i_fu_src_a[31];
    sign_b_s = signed_b_s & i_fu_src_b[31];
    mag_a_s  = magnitude(i_fu_src_a, signed_a_s);
    mag_b_s  = magnitude(i_fu_src_b, signed_b_s);
  end

  // One shift-add step: the multiplier sits in the low half and is consumed LSB-first.
  always_comb begin
    partial_s = {1'b0, product_r[63:32]} + {1'b0, (product_r[0] ? mcand_r : 32'd0)};
    step_s    = {partial_s, product_r[31:1]};
    if (neg_r) begin
      final_s = ~step_s + 64'd1;
    end else begin
      final_s = step_s;
    end
    case (op_r)
      2'b00:   half_s = final_s[31:0];
      default: half_s = final_s[63:32];
    endcase
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    broadcast_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_fu_valid && !i_flush) begin
          accept_s     = 1'b1;
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_next_s = IDLE;
        end else if (count_r == 5'd31) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (i_flush) begin
          state_next_s = IDLE;
        end else if (i_cdb_grant) begin
          broadcast_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture on accept, one iteration per BUSY cycle, result capture on the last one.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      op_r       <= 2'b00;
      tag_r      <= '0;
      neg_r      <= 1'b0;
      mcand_r    <= 32'd0;
      product_r  <= 64'd0;
      count_r    <= 5'd0;
      cdb_data_r <= 32'd0;
    end else if (accept_s) begin
      op_r      <= i_fu_insn[13:12];
      tag_r     <= i_fu_tag;
      neg_r     <= sign_a_s ^ sign_b_s;
      mcand_r   <= mag_a_s;
      product_r <= {32'd0, mag_b_s};
      count_r   <= 5'd0;
    end else if ((state_r == BUSY) && !i_flush) begin
      count_r <= count_r + 5'd1;
      if (count_r == 5'd31) begin
        product_r  <= final_s;
        cdb_data_r <= half_s;
      end else begin
        product_r  <= step_s;
      end
    end
  end

  assign o_fu_stall = (state_r != IDLE);
  assign o_cdb_req  = (state_r == DONE);
  assign o_cdb_en   = broadcast_s;
  assign o_cdb_data = cdb_data_r;
  assign o_cdb_tag  = tag_r;

endmodule

// File: tb/tb_iterative_mul_fu.sv
// Randomised and directed bench for iterative_mul_fu against a 64-bit arithmetic model.
module tb_iterative_mul_fu;
  import procyon_types::*;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            i_flush;
  logic            i_fu_valid;
  procyon_opcode_t i_fu_opcode;
  procyon_addr_t   i_fu_iaddr;
  logic [31:0]     i_fu_insn;
  procyon_data_t   i_fu_src_a;
  procyon_data_t   i_fu_src_b;
  procyon_tag_t    i_fu_tag;
  logic            o_fu_stall;
  logic            o_cdb_req;
  logic            i_cdb_grant;
  logic            o_cdb_en;
  procyon_data_t   o_cdb_data;
  procyon_tag_t    o_cdb_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iterative_mul_fu dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_flush     (i_flush),
    .i_fu_valid  (i_fu_valid),
    .i_fu_opcode (i_fu_opcode),
    .i_fu_iaddr  (i_fu_iaddr),
    .i_fu_insn   (i_fu_insn),
    .i_fu_src_a  (i_fu_src_a),
    .i_fu_src_b  (i_fu_src_b),
    .i_fu_tag    (i_fu_tag),
    .o_fu_stall  (o_fu_stall),
    .o_cdb_req   (o_cdb_req),
    .i_cdb_grant (i_cdb_grant),
    .o_cdb_en    (o_cdb_en),
    .o_cdb_data  (o_cdb_data),
    .o_cdb_tag   (o_cdb_tag)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits by its signedness and multiply modulo 2^64.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  // Presents an op in an IDLE cycle; returns in the first cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input procyon_tag_t tg, input bit keep_valid);
    logic [31:0] insn;
    insn        = $urandom;
    insn[13:12] = op;
    i_fu_valid  = 1'b1;
    i_fu_insn   = insn;
    i_fu_src_a  = a;
    i_fu_src_b  = b;
    i_fu_tag    = tg;
    i_fu_opcode = procyon_opcode_t'($urandom);
    i_fu_iaddr  = $urandom;
    settle();
    check_eq("issue_ready", {63'd0, o_fu_stall}, 64'd0);
    next_cycle();
    if (!keep_valid) i_fu_valid = 1'b0;
    i_fu_src_a = $urandom;
    i_fu_src_b = $urandom;
    i_fu_tag   = procyon_tag_t'($urandom);
    i_fu_insn  = $urandom;
  endtask

  // Counts cycles from T+1 until o_cdb_req, checking stall and silence meanwhile.
  task automatic wait_done(input bit grant_early);
    int bad;
    int lat;
    bad = 0;
    lat = 1;
    i_cdb_grant = grant_early;
    settle();
    while (!o_cdb_req && lat < 80) begin
      if (!o_fu_stall || o_cdb_en) bad++;
      next_cycle();
      settle();
      lat++;
    end
    check_eq("busy_stall", 64'(bad), 64'd0);
    check_eq("latency", 64'(lat), 64'd33);
  endtask

  // Holds off the grant for gdelay cycles, then grants and checks the single broadcast.
  task automatic finish_op(input logic [31:0] exp, input procyon_tag_t tg, input int gdelay);
    for (int i = 0; i < gdelay; i++) begin
      i_cdb_grant = 1'b0;
      #1;
      check_eq("hold_req", {63'd0, o_cdb_req}, 64'd1);
      check_eq("hold_en", {63'd0, o_cdb_en}, 64'd0);
      check_eq("hold_data", 64'(o_cdb_data), 64'(exp));
      check_eq("hold_tag", 64'(o_cdb_tag), 64'(tg));
      next_cycle();
      settle();
    end
    i_cdb_grant = 1'b1;
    #1;
    check_eq("cdb_en", {63'd0, o_cdb_en}, 64'd1);
    check_eq("cdb_data", 64'(o_cdb_data), 64'(exp));
    check_eq("cdb_tag", 64'(o_cdb_tag), 64'(tg));
    check_eq("bcast_stall", {63'd0, o_fu_stall}, 64'd1);
    next_cycle();
    i_cdb_grant = 1'b0;
    settle();
    check_eq("post_stall", {63'd0, o_fu_stall}, 64'd0);
    check_eq("post_req", {63'd0, o_cdb_req}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input procyon_tag_t tg, input int gdelay, input bit grant_early);
    issue(op, a, b, tg, 1'b0);
    wait_done(grant_early);
    finish_op(ref_mul(op, a, b), tg, gdelay);
  endtask

  initial begin
    logic [1:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    procyon_tag_t tg;

    n_rst       = 1'b0;
    i_flush     = 1'b0;
    i_fu_valid  = 1'b0;
    i_fu_opcode = '0;
    i_fu_iaddr  = 32'd0;
    i_fu_insn   = 32'd0;
    i_fu_src_a  = 32'd0;
    i_fu_src_b  = 32'd0;
    i_fu_tag    = '0;
    i_cdb_grant = 1'b0;
    repeat (3) next_cycle();
    settle();
    check_eq("rst_stall", {63'd0, o_fu_stall}, 64'd0);
    check_eq("rst_req", {63'd0, o_cdb_req}, 64'd0);
    check_eq("rst_en", {63'd0, o_cdb_en}, 64'd0);
    check_eq("rst_data", 64'(o_cdb_data), 64'd0);
    check_eq("rst_tag", 64'(o_cdb_tag), 64'd0);
    n_rst = 1'b1;
    next_cycle();

    // Directed vectors, including grant held high throughout and a long grant hold-off.
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, procyon_tag_t'(5), 0, 1'b1);
    check_eq("mul_neg_ref", 64'(ref_mul(2'b00, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, procyon_tag_t'(1), 0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, procyon_tag_t'(2), 1, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, procyon_tag_t'(3), 0, 1'b0);
    run_op(2'b01, 32'h1234_5678, 32'h8765_4321, procyon_tag_t'(9), 10, 1'b0);

    // Flush while the counter reads 12, then an immediate new accept.
    issue(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, procyon_tag_t'(7), 1'b0);
    repeat (12) next_cycle();
    i_flush = 1'b1;
    settle();
    check_eq("flush_busy_req", {63'd0, o_cdb_req}, 64'd0);
    next_cycle();
    i_flush = 1'b0;
    settle();
    check_eq("flush_busy_stall", {63'd0, o_fu_stall}, 64'd0);
    run_op(2'b10, 32'h8000_0001, 32'hFFFF_0000, procyon_tag_t'(11), 0, 1'b0);

    // Flush and grant collide in DONE: no broadcast, back to IDLE.
    issue(2'b11, 32'hCAFE_0001, 32'h0000_0003, procyon_tag_t'(13), 1'b0);
    wait_done(1'b0);
    i_flush     = 1'b1;
    i_cdb_grant = 1'b1;
    #1;
    check_eq("flush_grant_en", {63'd0, o_cdb_en}, 64'd0);
    next_cycle();
    i_flush     = 1'b0;
    i_cdb_grant = 1'b0;
    settle();
    check_eq("flush_done_stall", {63'd0, o_fu_stall}, 64'd0);
    check_eq("flush_done_req", {63'd0, o_cdb_req}, 64'd0);

    // Issue together with flush in IDLE is dropped.
    i_fu_valid = 1'b1;
    i_flush    = 1'b1;
    next_cycle();
    i_fu_valid = 1'b0;
    i_flush    = 1'b0;
    settle();
    check_eq("flush_idle_stall", {63'd0, o_fu_stall}, 64'd0);

    // Reset in the middle of BUSY abandons the op.
    issue(2'b00, 32'h0000_1111, 32'h0000_2222, procyon_tag_t'(21), 1'b0);
    repeat (5) next_cycle();
    n_rst = 1'b0;
    next_cycle();
    n_rst = 1'b1;
    settle();
    check_eq("rst_busy_stall", {63'd0, o_fu_stall}, 64'd0);
    check_eq("rst_busy_req", {63'd0, o_cdb_req}, 64'd0);
    check_eq("rst_busy_data", 64'(o_cdb_data), 64'd0);
    check_eq("rst_busy_tag", 64'(o_cdb_tag), 64'd0);
    next_cycle();

    // Back-to-back with valid held high: second op accepted right after the broadcast.
    issue(2'b01, 32'hFFFF_FFF9, 32'h0000_0013, procyon_tag_t'(30), 1'b1);
    i_fu_insn[13:12] = 2'b11;
    i_fu_src_a       = 32'hABCD_1234;
    i_fu_src_b       = 32'h9876_FEDC;
    i_fu_tag         = procyon_tag_t'(31);
    wait_done(1'b0);
    finish_op(ref_mul(2'b01, 32'hFFFF_FFF9, 32'h0000_0013), procyon_tag_t'(30), 2);
    next_cycle();
    i_fu_valid = 1'b0;
    wait_done(1'b0);
    finish_op(ref_mul(2'b11, 32'hABCD_1234, 32'h9876_FEDC), procyon_tag_t'(31), 0);

    // Random ops with occasional corner operands and random grant delays.
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      tg = procyon_tag_t'($urandom);
      run_op(op, a, b, tg, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
